// File: rtl/buzzer_arbiter.sv
// First-buzz arbiter for the four-player quiz buzzer: edge detect, round-robin tie-break, timed window.
// Optional false-start penalties are compiled in with `define FALSE_START_EN.
module buzzer_arbiter #(
    parameter int WINDOW_CYCLES = 500000000,
    parameter int CNT_W         = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] buzz_in,
    input  logic       arm,
    input  logic       clear,
    output logic       armed,
    output logic       winner_valid,
    output logic [1:0] winner_id,
    output logic [3:0] winner_onehot,
    output logic       timeout,
    output logic [3:0] penalty
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam bit               TIMEOUT_EN = (WINDOW_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WINDOW_CYCLES - 1);

    state_t             state_r;
    logic [3:0]         prev_buzz_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [1:0]         rr_ptr_r;
    logic [3:0]         penalty_r;
    logic               armed_r;
    logic               winner_valid_r;
    logic [1:0]         winner_id_r;
    logic [3:0]         winner_onehot_r;
    logic               timeout_r;

    logic [3:0]         edge_s;
    logic [3:0]         eligible_s;
    logic               hit_s;
    logic [1:0]         pick_s;
    logic               last_s;

    // Round-robin pick: lowest offset from ptr wins, so scan offsets high-to-low and let the last hit stand.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Rising-edge detect, eligibility and arbitration for the current cycle.
    always_comb begin
        edge_s         = buzz_in & ~prev_buzz_r;
        eligible_s     = edge_s & ~penalty_r;
        {hit_s, pick_s} = rr_pick(eligible_s, rr_ptr_r);
        last_s         = TIMEOUT_EN && (cnt_r == LAST_CNT);
    end

    // Round FSM with registered outputs; clear beats arm, an edge beats the final-cycle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            prev_buzz_r     <= 4'b0000;
            cnt_r           <= '0;
            rr_ptr_r        <= 2'd0;
            penalty_r       <= 4'b0000;
            armed_r         <= 1'b0;
            winner_valid_r  <= 1'b0;
            winner_id_r     <= 2'd0;
            winner_onehot_r <= 4'b0000;
            timeout_r       <= 1'b0;
        end else begin
            prev_buzz_r <= buzz_in;
`ifdef FALSE_START_EN
            // Presses while idle are false starts; they survive clear and only drop when a round ends.
            if (state_r == IDLE) begin
                penalty_r <= penalty_r | edge_s;
            end
`else
            penalty_r <= 4'b0000;
`endif
            if (clear) begin
                state_r         <= IDLE;
                armed_r         <= 1'b0;
                winner_valid_r  <= 1'b0;
                winner_id_r     <= 2'd0;
                winner_onehot_r <= 4'b0000;
                timeout_r       <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (arm) begin
                            state_r <= ARMED;
                            cnt_r   <= '0;
                            armed_r <= 1'b1;
                        end
                    end
                    ARMED: begin
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (hit_s) begin
                            state_r         <= LOCKED;
                            armed_r         <= 1'b0;
                            winner_valid_r  <= 1'b1;
                            winner_id_r     <= pick_s;
                            winner_onehot_r <= 4'b0001 << pick_s;
                            rr_ptr_r        <= pick_s + 2'd1;
                            penalty_r       <= 4'b0000;
                        end else if (last_s) begin
                            state_r   <= EXPIRED;
                            armed_r   <= 1'b0;
                            timeout_r <= 1'b1;
                            penalty_r <= 4'b0000;
                        end
                    end
                    LOCKED: begin
                        state_r <= LOCKED;
                    end
                    EXPIRED: begin
                        if (arm) begin
                            state_r   <= ARMED;
                            cnt_r     <= '0;
                            armed_r   <= 1'b1;
                            timeout_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign armed         = armed_r;
    assign winner_valid  = winner_valid_r;
    assign winner_id     = winner_id_r;
    assign winner_onehot = winner_onehot_r;
    assign timeout       = timeout_r;
    assign penalty       = penalty_r;

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Sits directly downstream of the four-channel buzzer debouncer in the quiz-buzzer design.
- Consumes the four debounced buzzer levels and detects rising edges.
- Arbitrates which player buzzed first during an armed round and locks out the others.
- Presents the winner to the display/LED stage; a round can also end by timeout.

Parameters:
- WINDOW_CYCLES, 500000000, armed-window length in clk cycles (10 s at 50 MHz); 0 = no timeout.
- CNT_W, 29, width of the window counter; must satisfy WINDOW_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- buzz_in  in  4  debounced buzzer levels, active-high, bit i = player i
- arm  in  1  single-cycle pulse from quizmaster: start round
- clear  in  1  single-cycle pulse from quizmaster: abort/end round, return to IDLE
- armed  out  1  high while in ARMED
- winner_valid  out  1  high while in LOCKED
- winner_id  out  2  index of winning player; valid when winner_valid=1
- winner_onehot  out  4  one-hot of winner_id while LOCKED, else 0
- timeout  out  1  high while in EXPIRED
- penalty  out  4  false-start flags (see Optional Feature); 0 when feature is compiled out

Behaviour:
- Reset: state=IDLE; all outputs 0; prev_buzz=4'b0000; window counter=0; rr_ptr=0.
- Edge detect: prev_buzz <= buzz_in every cycle in all states. edge = buzz_in & ~prev_buzz.
  - A buzzer already held when the round is armed never wins until it is released and pressed again.
- States: IDLE, ARMED, LOCKED, EXPIRED (encoded as 2 bits).
- IDLE:
  - arm -> ARMED; window counter loads 0.
  - Edges are ignored, except as described under Optional Feature.
- ARMED:
  - Counter increments each cycle.
  - Any eligible edge -> LOCKED in the next cycle.
  - Otherwise, if WINDOW_CYCLES != 0 and counter == WINDOW_CYCLES-1 -> EXPIRED.
  - An edge in that same final cycle wins over timeout.
  - arm while ARMED: ignored, counter not restarted.
- Arbitration with simultaneous edges in one cycle: round-robin.
  - Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... mod 4; the first set bit wins.
  - On entry to LOCKED, rr_ptr <= winner_id + 1 (2-bit wrap, 3 -> 0).
- LOCKED:
  - winner_id/onehot held constant; all further edges ignored.
  - arm ignored; only clear exits.
- EXPIRED:
  - timeout=1.
  - arm -> ARMED with counter restarted at 0.
  - clear -> IDLE.
- clear: from any state -> IDLE next cycle; winner/timeout outputs drop to 0. clear together with arm: clear wins.
- Latency:
  - edge sampled at clk edge N (buzz_in=1, prev_buzz=0) -> winner_valid=1 after edge N+1 (one registered stage).
  - arm at edge N -> armed=1 after N+1.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- reset mid-round: immediate return to reset values, including rr_ptr and penalty.

Optional Feature:
- Macro: FALSE_START_EN.
- Defined:
  - Any edge on buzzer i while in IDLE sets penalty[i].
  - In ARMED, eligible edges = edge & ~penalty; penalized players cannot win that round.
  - penalty clears on reset and on entry to LOCKED or EXPIRED.
  - clear does not clear penalty, so a false start before arming carries into the next round.
  - If all four players are penalized, the round can end only by timeout or clear.
- Not defined:
  - penalty tied to 4'b0000; IDLE edges have no effect; eligible edges = edge.

Test Plan:
- Basic win: WINDOW_CYCLES=20; arm; 3 cycles later buzz_in=4'b0100 -> winner_valid=1, winner_id=2, winner_onehot=4'b0100 one cycle after the edge; later buzz_in=4'b0011 -> outputs unchanged; clear -> all 0.
- Tie, round-robin: rr_ptr=0; arm; buzz_in=4'b1010 in the same cycle -> winner_id=1. clear, release, arm; repeat 4'b1010 with rr_ptr=2 -> winner_id=3. Next tie 4'b1010 with rr_ptr=0 -> winner_id=1.
- Held-button/timeout: buzz_in[0] held from before arm, no other press; WINDOW_CYCLES=20 -> timeout=1 exactly 20 cycles after armed rose, winner_valid stays 0. Then arm -> armed=1, timeout=0.
- Boundary: edge on buzz_in[3] in the final window cycle (counter=19) -> LOCKED with winner_id=3, timeout stays 0. Also arm+clear in the same cycle from LOCKED -> IDLE.
- Reset mid-round: in LOCKED with winner_id=2, assert reset one cycle -> all outputs 0; next tie 4'b1111 after arm -> winner_id=0 (rr_ptr reset).
- FALSE_START_EN: press buzzer 1 in IDLE -> penalty=4'b0010; arm; buzz_in=4'b0011 in the same cycle -> winner_id=0, penalty -> 0 on LOCKED entry. Without the macro: same stimulus -> rr_ptr decides (rr_ptr=0 -> winner_id=0), penalty stays 0.
